// File: rtl/axis_width_conv.sv
`default_nettype none
// ============================================================================
// Module   : axis_width_conv
// Desc     : AXI4-Stream width converter, integer ratio down/up or pass-through
//            slice. Define AXIS_WCONV_NULL_DROP_EN to skip trailing null lanes
//            in DOWN mode.
// Revision : 1.0 - initial release
// ============================================================================
module axis_width_conv #(
    parameter int S_DWIDTH = 256,
    parameter int M_DWIDTH = 64,
    parameter int S_KEEP   = S_DWIDTH / 8,
    parameter int M_KEEP   = M_DWIDTH / 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [S_DWIDTH-1:0] s_axis_tdata,
    input  logic [S_KEEP-1:0]   s_axis_tkeep,
    input  logic                s_axis_tlast,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [M_DWIDTH-1:0] m_axis_tdata,
    output logic [M_KEEP-1:0]   m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready
);

    localparam int c_ratio  = (S_DWIDTH > M_DWIDTH) ? (S_DWIDTH / M_DWIDTH) : (M_DWIDTH / S_DWIDTH);
    localparam int c_lane_w = (c_ratio > 1) ? $clog2(c_ratio) : 1;

    // Holds the sink closed while in reset and for the edge that releases it.
    logic r_init;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_init <= 1'b0;
        else        r_init <= 1'b1;
    end

    if (S_DWIDTH > M_DWIDTH) begin : g_down
        typedef enum logic [0:0] {
            ST_IDLE = 1'b0,
            ST_SEND = 1'b1
        } state_t;

        state_t              r_state;
        logic [S_DWIDTH-1:0] r_hold_data;
        logic [S_KEEP-1:0]   r_hold_keep;
        logic                r_hold_last;
        logic [c_lane_w-1:0] r_lane;
        logic [c_lane_w-1:0] r_final;
        logic [M_DWIDTH-1:0] r_m_data;
        logic [M_KEEP-1:0]   r_m_keep;
        logic                r_m_last;
        logic                r_m_valid;

        logic [c_lane_w-1:0] w_load_final;
        logic [c_lane_w-1:0] w_next_lane;
        logic [M_DWIDTH-1:0] w_next_data;
        logic [M_KEEP-1:0]   w_next_keep;
        logic                w_final_hs;
        logic                w_s_ready;
        logic                w_load;

        assign w_final_hs  = (r_state == ST_SEND) && m_axis_tready && (r_lane == r_final);
        assign w_s_ready   = r_init && ((r_state == ST_IDLE) || w_final_hs);
        assign w_load      = s_axis_tvalid && w_s_ready;
        assign w_next_lane = r_lane + c_lane_w'(1);

`ifdef AXIS_WCONV_NULL_DROP_EN
        // Final lane is the highest lane with any byte enabled; lane 0 always goes out.
        always_comb begin
            w_load_final = '0;
            for (int i = 1; i < c_ratio; i++) begin
                if (|s_axis_tkeep[i*M_KEEP +: M_KEEP]) w_load_final = c_lane_w'(i);
            end
        end
`else
        assign w_load_final = c_lane_w'(c_ratio - 1);
`endif

        always_comb begin
            w_next_data = '0;
            w_next_keep = '0;
            for (int i = 0; i < c_ratio; i++) begin
                if (w_next_lane == c_lane_w'(i)) begin
                    w_next_data = r_hold_data[i*M_DWIDTH +: M_DWIDTH];
                    w_next_keep = r_hold_keep[i*M_KEEP +: M_KEEP];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state     <= ST_IDLE;
                r_hold_data <= '0;
                r_hold_keep <= '0;
                r_hold_last <= 1'b0;
                r_lane      <= '0;
                r_final     <= '0;
                r_m_data    <= '0;
                r_m_keep    <= '0;
                r_m_last    <= 1'b0;
                r_m_valid   <= 1'b0;
            end else if (w_load) begin
                // Lane 0 is presented straight from the sink so there is no bubble.
                r_state     <= ST_SEND;
                r_hold_data <= s_axis_tdata;
                r_hold_keep <= s_axis_tkeep;
                r_hold_last <= s_axis_tlast;
                r_lane      <= '0;
                r_final     <= w_load_final;
                r_m_data    <= s_axis_tdata[M_DWIDTH-1:0];
                r_m_keep    <= s_axis_tkeep[M_KEEP-1:0];
                r_m_last    <= s_axis_tlast && (w_load_final == '0);
                r_m_valid   <= 1'b1;
            end else if ((r_state == ST_SEND) && m_axis_tready) begin
                if (r_lane == r_final) begin
                    r_state   <= ST_IDLE;
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                end else begin
                    r_lane   <= w_next_lane;
                    r_m_data <= w_next_data;
                    r_m_keep <= w_next_keep;
                    r_m_last <= r_hold_last && (w_next_lane == r_final);
                end
            end
        end

        assign s_axis_tready = w_s_ready;
        assign m_axis_tdata  = r_m_data;
        assign m_axis_tkeep  = r_m_keep;
        assign m_axis_tlast  = r_m_last;
        assign m_axis_tvalid = r_m_valid;
    end else if (S_DWIDTH < M_DWIDTH) begin : g_up
        logic [M_DWIDTH-1:0] r_acc_data;
        logic [M_KEEP-1:0]   r_acc_keep;
        logic [c_lane_w-1:0] r_beat;
        logic [M_DWIDTH-1:0] r_m_data;
        logic [M_KEEP-1:0]   r_m_keep;
        logic                r_m_last;
        logic                r_m_valid;

        logic [M_DWIDTH-1:0] w_acc_data;
        logic [M_KEEP-1:0]   w_acc_keep;
        logic                w_s_ready;
        logic                w_load;
        logic                w_emit;

        assign w_s_ready = r_init && (!r_m_valid || m_axis_tready);
        assign w_load    = s_axis_tvalid && w_s_ready;
        assign w_emit    = s_axis_tlast || (r_beat == c_lane_w'(c_ratio - 1));

        always_comb begin
            w_acc_data = r_acc_data;
            w_acc_keep = r_acc_keep;
            for (int i = 0; i < c_ratio; i++) begin
                if (r_beat == c_lane_w'(i)) begin
                    w_acc_data[i*S_DWIDTH +: S_DWIDTH] = s_axis_tdata;
                    w_acc_keep[i*S_KEEP +: S_KEEP]     = s_axis_tkeep;
                end
            end
        end

        // Accumulator is cleared on every emit, so lanes above the last beat read as zero.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc_data <= '0;
                r_acc_keep <= '0;
                r_beat     <= '0;
                r_m_data   <= '0;
                r_m_keep   <= '0;
                r_m_last   <= 1'b0;
                r_m_valid  <= 1'b0;
            end else if (w_load && w_emit) begin
                r_m_data   <= w_acc_data;
                r_m_keep   <= w_acc_keep;
                r_m_last   <= s_axis_tlast;
                r_m_valid  <= 1'b1;
                r_acc_data <= '0;
                r_acc_keep <= '0;
                r_beat     <= '0;
            end else begin
                if (w_load) begin
                    r_acc_data <= w_acc_data;
                    r_acc_keep <= w_acc_keep;
                    r_beat     <= r_beat + c_lane_w'(1);
                end
                if (m_axis_tready) r_m_valid <= 1'b0;
            end
        end

        assign s_axis_tready = w_s_ready;
        assign m_axis_tdata  = r_m_data;
        assign m_axis_tkeep  = r_m_keep;
        assign m_axis_tlast  = r_m_last;
        assign m_axis_tvalid = r_m_valid;
    end else begin : g_pass
        logic [M_DWIDTH-1:0] r_m_data;
        logic [M_KEEP-1:0]   r_m_keep;
        logic                r_m_last;
        logic                r_m_valid;
        logic                w_s_ready;

        assign w_s_ready = r_init && (!r_m_valid || m_axis_tready);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_m_data  <= '0;
                r_m_keep  <= '0;
                r_m_last  <= 1'b0;
                r_m_valid <= 1'b0;
            end else if (s_axis_tvalid && w_s_ready) begin
                r_m_data  <= s_axis_tdata;
                r_m_keep  <= s_axis_tkeep;
                r_m_last  <= s_axis_tlast;
                r_m_valid <= 1'b1;
            end else if (m_axis_tready) begin
                r_m_valid <= 1'b0;
            end
        end

        assign s_axis_tready = w_s_ready;
        assign m_axis_tdata  = r_m_data;
        assign m_axis_tkeep  = r_m_keep;
        assign m_axis_tlast  = r_m_last;
        assign m_axis_tvalid = r_m_valid;
    end

endmodule
`default_nettype wire
